// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Constants and types shared by the SPI slave and the register bank behind it.
//   - SPI_ADDR_LEN / SPI_WORD_LEN : address and data word widths on the SPI link
//   - SPI_WAIT_LEN                : minimum master clocks between two strobes
//   - ADDR_ID / ADDR_STATUS / ADDR_ERR : fixed addresses of the special registers
//   - SPI_ID_VALUE                : default contents of the read-only ID register
//   - acc_kind_e                  : decoded class of an access address
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_ADDR_LEN = 8;
  localparam int SPI_WORD_LEN = 16;
  localparam int SPI_WAIT_LEN = 4;
  localparam int ERR_CNT_LEN  = 8;

  localparam logic [SPI_ADDR_LEN-1:0] ADDR_ID     = 8'hF0;
  localparam logic [SPI_ADDR_LEN-1:0] ADDR_STATUS = 8'hF1;
  localparam logic [SPI_ADDR_LEN-1:0] ADDR_ERR    = 8'hF2;

  localparam logic [SPI_WORD_LEN-1:0] SPI_ID_VALUE = 16'hA55A;

  typedef enum logic [2:0] {
    ACC_GEN,     // general read/write register
    ACC_ID,      // read-only identification word
    ACC_STATUS,  // sticky event bits, write-1-to-clear
    ACC_ERR,     // read-only invalid-access counter
    ACC_BAD      // unmapped address
  } acc_kind_e;

endpackage

// File: rtl/spi_strobe_edge.sv
// -----------------------------------------------------------------------------
// spi_strobe_edge
//   Turns a request level from the SPI slave into a single-cycle "go" strobe on
//   its rising edge. A level held high produces exactly one strobe; a new strobe
//   needs a low sample first.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst   : synchronous active-high reset
//     i_level : request level
//     o_go    : combinational one-cycle strobe (level high, previous sample low)
// -----------------------------------------------------------------------------
module spi_strobe_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_go
);

  // armed_q holds the inverse of the previous sample. Resetting it to 0 means
  // "disarmed", so a level still high when reset releases must drop to 0
  // before it can fire again, instead of firing spuriously on the first cycle.
  logic armed_q;
  logic armed_d;

  always_comb begin
    armed_d = ~i_level;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values present before the edge regardless of the
  // order in which always_ff blocks are evaluated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign o_go = i_level & armed_q;

endmodule

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
//   Register file sitting behind the SPI slave in the i_master_clock domain.
//   Each rising edge of the write/read request levels performs one access:
//     0 .. NUM_REGS-1 : general R/W registers
//     ADDR_ID         : read-only, returns ID_VALUE
//     ADDR_STATUS     : sticky event bits set by i_status, write-1-to-clear
//     ADDR_ERR        : read-only, returns the invalid-access count
//   Invalid accesses (writes to ID/ERR, any access to an unmapped address)
//   bump a saturating 8-bit counter.
//   Ports:
//     i_master_clock   : clock, rising edge
//     i_rst            : synchronous active-high reset
//     i_spi_write      : write request level
//     i_spi_read       : read request level
//     i_spi_addr       : access address
//     i_spi_data       : write data
//     i_status         : per-bit event inputs, OR-ed into STATUS every cycle
//     o_data_word_send : registered read data, held until the next read
//     o_regs           : flat copy of the general registers, reg k at
//                        [k*WORD_LEN +: WORD_LEN]
//     o_wr_pulse       : one-cycle pulse after a general register write
//     o_wr_addr        : address of that write
//     o_err_cnt        : saturating invalid-access count
// -----------------------------------------------------------------------------
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int                  ADDR_LEN = SPI_ADDR_LEN,
  parameter int                  WORD_LEN = SPI_WORD_LEN,
  parameter int                  NUM_REGS = 16,
  parameter logic [WORD_LEN-1:0] ID_VALUE = SPI_ID_VALUE
) (
  input  logic                         i_master_clock,
  input  logic                         i_rst,
  input  logic                         i_spi_write,
  input  logic                         i_spi_read,
  input  logic [ADDR_LEN-1:0]          i_spi_addr,
  input  logic [WORD_LEN-1:0]          i_spi_data,
  input  logic [WORD_LEN-1:0]          i_status,
  output logic [WORD_LEN-1:0]          o_data_word_send,
  output logic [NUM_REGS*WORD_LEN-1:0] o_regs,
  output logic                         o_wr_pulse,
  output logic [ADDR_LEN-1:0]          o_wr_addr,
  output logic [ERR_CNT_LEN-1:0]       o_err_cnt
);

  // ---------------------------------------------------------------------------
  // Strobe generation
  // ---------------------------------------------------------------------------
  logic wr_go;
  logic rd_go;

  spi_strobe_edge u_wr_edge (
    .i_clk   (i_master_clock),
    .i_rst   (i_rst),
    .i_level (i_spi_write),
    .o_go    (wr_go)
  );

  spi_strobe_edge u_rd_edge (
    .i_clk   (i_master_clock),
    .i_rst   (i_rst),
    .i_level (i_spi_read),
    .o_go    (rd_go)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WORD_LEN-1:0]    regs_q [NUM_REGS];
  logic [WORD_LEN-1:0]    regs_d [NUM_REGS];
  logic [WORD_LEN-1:0]    status_q,   status_d;
  logic [WORD_LEN-1:0]    rdata_q,    rdata_d;
  logic                   wr_pulse_q, wr_pulse_d;
  logic [ADDR_LEN-1:0]    wr_addr_q,  wr_addr_d;
  logic [ERR_CNT_LEN-1:0] err_cnt_q,  err_cnt_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  function automatic acc_kind_e decode(input logic [ADDR_LEN-1:0] addr);
    acc_kind_e kind;
    if (int'(addr) < NUM_REGS) begin
      kind = ACC_GEN;
    end else if (addr == ADDR_LEN'(ADDR_ID)) begin
      kind = ACC_ID;
    end else if (addr == ADDR_LEN'(ADDR_STATUS)) begin
      kind = ACC_STATUS;
    end else if (addr == ADDR_LEN'(ADDR_ERR)) begin
      kind = ACC_ERR;
    end else begin
      kind = ACC_BAD;
    end
    return kind;
  endfunction

  acc_kind_e           acc_kind;
  logic [WORD_LEN-1:0] gen_rd_val;
  logic [WORD_LEN-1:0] clr_mask;
  logic [1:0]          err_inc;
  logic [ERR_CNT_LEN:0] err_sum;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default at the top, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    acc_kind   = decode(i_spi_addr);
    gen_rd_val = '0;
    clr_mask   = '0;
    err_inc    = 2'd0;
    rdata_d    = rdata_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end

    // Read mux works on the pre-edge register values, so a simultaneous write
    // to the same address returns the old contents.
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(i_spi_addr) == k) begin
        gen_rd_val = regs_q[k];
      end
    end

    if (rd_go) begin
      unique case (acc_kind)
        ACC_GEN:    rdata_d = gen_rd_val;
        ACC_ID:     rdata_d = ID_VALUE;
        ACC_STATUS: rdata_d = status_q;
        ACC_ERR:    rdata_d = WORD_LEN'(err_cnt_q);
        default: begin
          rdata_d = '0;
          err_inc = err_inc + 2'd1;
        end
      endcase
    end

    if (wr_go) begin
      unique case (acc_kind)
        ACC_GEN: begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(i_spi_addr) == k) begin
              regs_d[k] = i_spi_data;
            end
          end
          wr_pulse_d = 1'b1;
          wr_addr_d  = i_spi_addr;
        end
        ACC_STATUS: clr_mask = i_spi_data;
        default:    err_inc  = err_inc + 2'd1;
      endcase
    end

    // Clear is applied before the OR, so an event arriving in the same cycle
    // as its clear keeps the bit set.
    status_d = (status_q & ~clr_mask) | i_status;

    // One spare bit catches the carry; any overflow pins the count at all-ones.
    err_sum   = {1'b0, err_cnt_q} + (ERR_CNT_LEN+1)'(err_inc);
    err_cnt_d = err_sum[ERR_CNT_LEN] ? '1 : err_sum[ERR_CNT_LEN-1:0];
  end

  // ---------------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------------
  // NOTE: the register array is reset explicitly because user logic consumes
  // o_regs directly and must see a defined configuration after reset; that
  // keeps it in flops rather than a RAM macro, which is fine at this size.
  always_ff @(posedge i_master_clock) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      status_q   <= '0;
      rdata_q    <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs[g*WORD_LEN +: WORD_LEN] = regs_q[g];
  end

  assign o_data_word_send = rdata_q;
  assign o_wr_pulse       = wr_pulse_q;
  assign o_wr_addr        = wr_addr_q;
  assign o_err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank
//   Directed stimulus for spi_reg_bank. A behavioural model of the register map
//   is checked against the DUT outputs on every falling edge, and each directed
//   step also checks hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_spi_reg_bank;
  import spi_pkg::*;

  localparam int AL = 8;
  localparam int WL = 16;
  localparam int NR = 16;
  localparam int FW = NR * WL;

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_write;
  logic          spi_read;
  logic [AL-1:0] spi_addr;
  logic [WL-1:0] spi_data;
  logic [WL-1:0] status_in;
  logic [WL-1:0] data_word_send;
  logic [FW-1:0] regs_flat;
  logic          wr_pulse;
  logic [AL-1:0] wr_addr;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  spi_reg_bank #(
    .ADDR_LEN (AL),
    .WORD_LEN (WL),
    .NUM_REGS (NR),
    .ID_VALUE (16'hA55A)
  ) dut (
    .i_master_clock   (clk),
    .i_rst            (rst),
    .i_spi_write      (spi_write),
    .i_spi_read       (spi_read),
    .i_spi_addr       (spi_addr),
    .i_spi_data       (spi_data),
    .i_status         (status_in),
    .o_data_word_send (data_word_send),
    .o_regs           (regs_flat),
    .o_wr_pulse       (wr_pulse),
    .o_wr_addr        (wr_addr),
    .o_err_cnt        (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: what the register map must look like after each edge.
  // ---------------------------------------------------------------------------
  logic [WL-1:0] m_regs [NR];
  logic [WL-1:0] m_status;
  logic [WL-1:0] m_rdata;
  logic          m_pulse;
  logic [AL-1:0] m_waddr;
  int            m_err;
  logic          m_wprev;   // previous level; 1 after reset so a held level must drop first
  logic          m_rprev;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      m_status = '0;
      m_rdata  = '0;
      m_pulse  = 1'b0;
      m_waddr  = '0;
      m_err    = 0;
      m_wprev  = 1'b1;
      m_rprev  = 1'b1;
    end else begin
      logic          wr, rd;
      logic [WL-1:0] clr;
      int            n_err;
      wr    = spi_write && !m_wprev;
      rd    = spi_read  && !m_rprev;
      clr   = '0;
      n_err = m_err;
      m_pulse = 1'b0;
      if (rd) begin
        if (spi_addr < NR)        m_rdata = m_regs[spi_addr];
        else if (spi_addr == 8'hF0) m_rdata = 16'hA55A;
        else if (spi_addr == 8'hF1) m_rdata = m_status;
        else if (spi_addr == 8'hF2) m_rdata = 16'(m_err);
        else begin
          m_rdata = 16'h0000;
          n_err++;
        end
      end
      if (wr) begin
        if (spi_addr < NR) begin
          m_regs[spi_addr] = spi_data;
          m_pulse = 1'b1;
          m_waddr = spi_addr;
        end else if (spi_addr == 8'hF1) begin
          clr = spi_data;
        end else begin
          n_err++;
        end
      end
      m_status = (m_status & ~clr) | status_in;
      m_err    = (n_err > 255) ? 255 : n_err;
      m_wprev  = spi_write;
      m_rprev  = spi_read;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic [FW-1:0] flat;
      for (int k = 0; k < NR; k++) flat[k*WL +: WL] = m_regs[k];
      check("model_rdata", data_word_send, m_rdata);
      check("model_regs", regs_flat, flat);
      check("model_wr_pulse", wr_pulse, m_pulse);
      if (m_pulse) check("model_wr_addr", wr_addr, m_waddr);
      check("model_err_cnt", err_cnt, m_err[7:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_read(input logic [AL-1:0] a, output logic [WL-1:0] d);
    spi_addr = a;
    spi_read = 1'b1;
    @(negedge clk);
    d = data_word_send;
    spi_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AL-1:0] a, input logic [WL-1:0] v);
    spi_addr  = a;
    spi_data  = v;
    spi_write = 1'b1;
    @(negedge clk);
    spi_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WL-1:0] d;
    int pulses;

    rst = 1'b1; spi_write = 1'b0; spi_read = 1'b0;
    spi_addr = '0; spi_data = '0; status_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    started = 1'b1;

    // Reset state and basic reads
    check("reset_err_cnt", err_cnt, 8'h00);
    check("reset_regs", regs_flat, '0);
    do_read(8'h00, d); check("rd_00_after_reset", d, 16'h0000);
    do_read(8'h05, d); check("rd_05_after_reset", d, 16'h0000);
    do_read(8'hF0, d); check("rd_id", d, 16'hA55A);
    check("err_after_valid_reads", err_cnt, 8'h00);

    // Held write level produces exactly one access
    spi_addr = 8'h03; spi_data = 16'h1234; spi_write = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_pulse) begin
        pulses++;
        check("held_wr_addr", wr_addr, 8'h03);
      end
    end
    spi_write = 1'b0;
    @(negedge clk);
    check("held_wr_pulse_count", pulses, 1);
    check("reg3_after_write", regs_flat[63:48], 16'h1234);
    do_read(8'h03, d); check("rd_03", d, 16'h1234);

    // Sticky status, write-1-to-clear, set wins over clear
    status_in = 16'h0081;
    @(negedge clk);
    status_in = 16'h0000;
    do_read(8'hF1, d); check("status_set", d, 16'h0081);
    do_write(8'hF1, 16'h0001);
    do_read(8'hF1, d); check("status_clr_bit0", d, 16'h0080);
    spi_addr = 8'hF1; spi_data = 16'h0080; spi_write = 1'b1; status_in = 16'h0080;
    @(negedge clk);
    spi_write = 1'b0; status_in = 16'h0000;
    @(negedge clk);
    do_read(8'hF1, d); check("status_set_wins", d, 16'h0080);
    do_write(8'hF1, 16'h0080);
    do_read(8'hF1, d); check("status_clr_bit7", d, 16'h0000);

    // Invalid accesses and the error counter
    do_write(8'hF0, 16'hFFFF);
    do_read(8'h40, d); check("rd_unmapped", d, 16'h0000);
    do_write(8'hF2, 16'h1111);
    check("err_cnt_3", err_cnt, 8'h03);
    do_read(8'hF0, d); check("id_unchanged", d, 16'hA55A);
    do_read(8'hF2, d); check("rd_err", d, 16'h0003);
    spi_addr = 8'h90; spi_data = 16'h7777; spi_write = 1'b1; spi_read = 1'b1;
    @(negedge clk);
    spi_write = 1'b0; spi_read = 1'b0;
    check("err_cnt_double", err_cnt, 8'h05);
    @(negedge clk);
    for (int i = 0; i < 300; i++) do_write(8'h80, 16'(i));
    check("err_cnt_saturated", err_cnt, 8'hFF);
    do_read(8'hEE, d);
    check("err_cnt_no_wrap", err_cnt, 8'hFF);

    // Simultaneous write and read of the same register
    do_write(8'h02, 16'h00AA);
    spi_addr = 8'h02; spi_data = 16'h5555; spi_write = 1'b1; spi_read = 1'b1;
    @(negedge clk);
    spi_write = 1'b0; spi_read = 1'b0;
    check("simul_rd_old_value", data_word_send, 16'h00AA);
    check("simul_reg2_new", regs_flat[47:32], 16'h5555);
    @(negedge clk);

    // Reset right after a write edge; held level must not re-fire
    spi_addr = 8'h05; spi_data = 16'hBEEF; spi_write = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_regs_zero", regs_flat, '0);
    check("rst_rdata_zero", data_word_send, 16'h0000);
    check("rst_err_zero", err_cnt, 8'h00);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (wr_pulse) pulses++;
    end
    check("held_after_rst_no_pulse", pulses, 0);
    check("held_after_rst_regs", regs_flat, '0);
    spi_write = 1'b0;
    @(negedge clk);
    spi_write = 1'b1;
    @(negedge clk);
    check("rearm_pulse", wr_pulse, 1'b1);
    check("rearm_reg5", regs_flat[95:80], 16'hBEEF);
    spi_write = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Register-file stage directly downstream of the SPI slave; lives in the i_master_clock domain.
- Consumes the slave's decoded spi_write / spi_read / spi_addr / spi_data outputs and performs one register access per strobe.
- Returns read data to the slave's data_word_send input.
- Exposes general-purpose config registers, a sticky write-1-to-clear status register and an invalid-access counter to the user logic.

Parameters:
- ADDR_LEN, 8, width of the SPI address.
- WORD_LEN, 16, width of the SPI data word and of every register.
- NUM_REGS, 16, number of general R/W registers, mapped at addresses 0..NUM_REGS-1 (must be ≤ 0xF0).
- ID_VALUE, 16'hA55A, constant returned from the ID register.

Ports:
- i_master_clock  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_spi_write  in  1  write request level from the SPI slave.
- i_spi_read  in  1  read request level from the SPI slave.
- i_spi_addr  in  ADDR_LEN  register address.
- i_spi_data  in  WORD_LEN  write data.
- i_status  in  WORD_LEN  per-bit event inputs, sampled every cycle.
- o_data_word_send  out  WORD_LEN  read data to the slave; registered.
- o_regs  out  NUM_REGS*WORD_LEN  flat copy of the R/W registers; reg k occupies bits [k*WORD_LEN +: WORD_LEN].
- o_wr_pulse  out  1  one-cycle pulse when a valid R/W register is written.
- o_wr_addr  out  ADDR_LEN  address of the last write; valid while o_wr_pulse=1.
- o_err_cnt  out  8  saturating count of invalid accesses.

Behaviour:
- Reset (i_rst=1 at a clock edge): all general registers, o_data_word_send, o_wr_pulse, o_wr_addr, status register, o_err_cnt and the edge-detect flops go to 0. Reset overrides everything in the same cycle, including mid-access; an access whose rising edge coincides with reset is lost.
- Edge detection:
  - Register i_spi_write and i_spi_read every cycle.
  - wr_go = i_spi_write & ~prev_write; rd_go = i_spi_read & ~prev_read.
  - A held level produces exactly one access. Re-arm requires a 0 sample.
- Address map:
  - 0..NUM_REGS-1: general R/W registers.
  - 0xF0: ID, read-only, reads ID_VALUE.
  - 0xF1: STATUS, sticky; write-1-to-clear.
  - 0xF2: ERR, read-only; reads {8'h00, o_err_cnt}.
  - Any other address is invalid.
- Write (wr_go):
  - General register: the register takes i_spi_data at the edge; o_wr_pulse=1 for exactly one cycle (the next cycle); o_wr_addr = i_spi_addr.
  - STATUS: clear the bits where i_spi_data=1.
  - ID, ERR or an unmapped address: no state change except o_err_cnt+1.
- Read (rd_go): o_data_word_send takes the addressed value on the next edge (1-cycle latency) and holds it until the next rd_go or reset. An unmapped address returns 16'h0000 and increments o_err_cnt.
- STATUS update each cycle: status <= (status & ~clr_mask) | i_status. clr_mask is nonzero only in a STATUS-write cycle. A set and clear on the same bit in the same cycle leaves the bit set (set wins).
- Simultaneous wr_go and rd_go:
  - Both are executed.
  - The read returns the pre-write value.
  - If both are invalid, o_err_cnt increments by 2, saturating.
- o_err_cnt saturates at 8'hFF and never wraps. Only reset clears it.
- No backpressure: the SPI framing guarantees at least SPI_WAIT_LEN master clocks between strobes, and every access completes in one cycle.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_ADDR_LEN, SPI_WORD_LEN and SPI_WAIT_LEN.
  - Address constants ADDR_ID=8'hF0, ADDR_STATUS=8'hF1, ADDR_ERR=8'hF2.
  - ID_VALUE default.
- One natural sub-module, spi_strobe_edge: a 1-bit rising-edge detector with synchronous reset, instantiated twice (write and read).
- Register array, decode and read mux live in spi_reg_bank itself.

Test Plan:
- Reset then read addr 0x00, 0x05 and 0xF0 → 16'h0000, 16'h0000, 16'hA55A, each one cycle after rd_go; o_err_cnt=0.
- Write 16'h1234 to addr 0x03 with i_spi_write held 10 cycles → exactly one o_wr_pulse with o_wr_addr=0x03; o_regs[63:48]=16'h1234; read of 0x03 returns 16'h1234.
- Pulse i_status=16'h0081 for one cycle → read 0xF1 returns 16'h0081. Write 16'h0001 to 0xF1 → reads 16'h0080. Write 16'h0080 to 0xF1 in the same cycle i_status[7]=1 → bit 7 stays 1.
- Write to 0xF0, read 0x40, write to 0xF2 → o_err_cnt=3; ID still reads 16'hA55A; read 0xF2 returns 16'h0003. Then 300 invalid accesses → o_err_cnt=8'hFF, no wrap.
- Addr 0x02 holds 16'h00AA; rising edges of write (data 16'h5555) and read on addr 0x02 in the same cycle → o_data_word_send=16'h00AA and reg 2 becomes 16'h5555.
- Assert i_rst the cycle after a write's rising edge → all registers, o_data_word_send and o_err_cnt read 0. A write level still held after reset produces no access until it is deasserted and reasserted.
